// File: rtl/fsm_updown_decoder_if.sv
// fsm_updown_decoder_if
// Bundles the sample input, the clear request and the decoded outputs of
// fsm_updown_decoder. The master side supplies samples and consumes the
// decoded results; the slave side is the decoder itself.
interface fsm_updown_decoder_if #(
  parameter int POS_W = 8
);

  // sample side
  logic [1:0]       z_in;
  logic             z_valid;
  logic             clr;

  // decoded side
  logic             dir_out;
  logic             step;
  logic [POS_W-1:0] pos;
  logic             err;
  logic [7:0]       err_cnt;
  logic             locked;

  modport master (
    output z_in,
    output z_valid,
    output clr,
    input  dir_out,
    input  step,
    input  pos,
    input  err,
    input  err_cnt,
    input  locked
  );

  modport slave (
    input  z_in,
    input  z_valid,
    input  clr,
    output dir_out,
    output step,
    output pos,
    output err,
    output err_cnt,
    output locked
  );

endinterface

// File: rtl/fsm_updown_decoder.sv
// fsm_updown_decoder
// Receive-side decoder for a 2-bit modulo-4 up/down stepping source. From
// successive valid samples it recovers the count direction, a per-step pulse,
// a wrapping signed position and illegal-jump (delta 2) errors. Too many
// consecutive illegal jumps park the decoder in FAULT until clr or reset.
//
// Optional feature macro: FSM_UPDOWN_DECODER_ERRCNT_EN
//   defined   : err_cnt is an 8-bit saturating total of illegal jumps
//   undefined : err_cnt is tied to 8'h00 and no counter register exists
// err, the consecutive-error count and FAULT entry are identical either way.
module fsm_updown_decoder #(
  parameter int POS_W     = 8,
  parameter int ERR_LIMIT = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  fsm_updown_decoder_if.slave       bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCKED = 2'd1,
    FAULT  = 2'd2
  } state_t;

  // consecutive-error threshold in the width of the counter that tracks it
  localparam logic [3:0] ERR_LIMIT_C = 4'(ERR_LIMIT);

  state_t           state_reg;
  logic [1:0]       prev_reg;
  logic [3:0]       cons_reg;
  logic             dir_reg;
  logic             step_reg;
  logic             err_reg;
  logic             locked_reg;
  logic [POS_W-1:0] pos_reg;

  // modulo-4 distance from the held reference to the new sample;
  // 1 = one step up, 3 = one step down, 2 = ambiguous jump
  logic [1:0]       delta;
  logic [3:0]       cons_inc;

  assign delta    = bus.z_in - prev_reg;
  assign cons_inc = cons_reg + 4'd1;

`ifdef FSM_UPDOWN_DECODER_ERRCNT_EN
  logic [7:0] err_cnt_reg;
`endif

  // decoder state machine with registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      prev_reg    <= 2'd0;
      cons_reg    <= 4'd0;
      dir_reg     <= 1'b0;
      step_reg    <= 1'b0;
      err_reg     <= 1'b0;
      locked_reg  <= 1'b0;
      pos_reg     <= '0;
`ifdef FSM_UPDOWN_DECODER_ERRCNT_EN
      err_cnt_reg <= 8'd0;
`endif
    end else begin
      // pulses are one cycle wide unless re-asserted below
      step_reg <= 1'b0;
      err_reg  <= 1'b0;

      if (bus.clr) begin
        // clr overrides any sample in the same cycle; direction is kept
        state_reg   <= IDLE;
        cons_reg    <= 4'd0;
        locked_reg  <= 1'b0;
        pos_reg     <= '0;
`ifdef FSM_UPDOWN_DECODER_ERRCNT_EN
        err_cnt_reg <= 8'd0;
`endif
      end else if (bus.z_valid) begin
        case (state_reg)
          IDLE: begin
            // first sample only establishes the reference
            prev_reg   <= bus.z_in;
            state_reg  <= LOCKED;
            locked_reg <= 1'b1;
          end

          LOCKED: begin
            case (delta)
              2'd1: begin
                step_reg <= 1'b1;
                dir_reg  <= 1'b0;
                pos_reg  <= pos_reg + 1'b1;
                prev_reg <= bus.z_in;
                cons_reg <= 4'd0;
              end
              2'd3: begin
                step_reg <= 1'b1;
                dir_reg  <= 1'b1;
                pos_reg  <= pos_reg - 1'b1;
                prev_reg <= bus.z_in;
                cons_reg <= 4'd0;
              end
              2'd2: begin
                // direction unknowable; resync reference, count the error
                err_reg  <= 1'b1;
                prev_reg <= bus.z_in;
                cons_reg <= cons_inc;
`ifdef FSM_UPDOWN_DECODER_ERRCNT_EN
                if (err_cnt_reg != 8'hFF) begin
                  err_cnt_reg <= err_cnt_reg + 8'd1;
                end
`endif
                if (cons_inc == ERR_LIMIT_C) begin
                  state_reg  <= FAULT;
                  locked_reg <= 1'b0;
                end
              end
              default: begin
                // delta 0: source has not moved, nothing changes
              end
            endcase
          end

          FAULT: begin
            // samples are ignored until clr or reset
          end

          default: begin
            state_reg  <= IDLE;
            locked_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.dir_out = dir_reg;
  assign bus.step    = step_reg;
  assign bus.err     = err_reg;
  assign bus.pos     = pos_reg;
  assign bus.locked  = locked_reg;

`ifdef FSM_UPDOWN_DECODER_ERRCNT_EN
  assign bus.err_cnt = err_cnt_reg;
`else
  assign bus.err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_fsm_updown_decoder.sv
// tb_fsm_updown_decoder
// Scoreboard bench: each driven cycle pushes the reference model's expected
// outputs into a queue; after the clock edge the entry is popped and every
// output field is compared through check_eq.
module tb_fsm_updown_decoder;

  localparam int POS_W     = 8;
  localparam int ERR_LIMIT = 3;

  logic clk;
  logic reset;

  fsm_updown_decoder_if #(.POS_W(POS_W)) bus ();

  fsm_updown_decoder #(
    .POS_W     (POS_W),
    .ERR_LIMIT (ERR_LIMIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       step;
    logic       err;
    logic       dir_out;
    logic       locked;
    logic [7:0] pos;
    logic [7:0] err_cnt;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  // reference model: 0 idle, 1 locked, 2 fault
  int m_state;
  int m_prev;
  int m_pos;
  int m_cons;
  int m_errcnt;
  int m_dir;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state  = 0;
    m_prev   = 0;
    m_pos    = 0;
    m_cons   = 0;
    m_errcnt = 0;
    m_dir    = 0;
  endtask

  // advance the model by one cycle and push the expected outputs
  task automatic model_push(input logic zv, input logic [1:0] z, input logic c);
    exp_t e;
    int   d;
    e.step = 1'b0;
    e.err  = 1'b0;
    if (c) begin
      m_state  = 0;
      m_pos    = 0;
      m_cons   = 0;
      m_errcnt = 0;
    end else if (zv) begin
      if (m_state == 0) begin
        m_prev  = int'(z);
        m_state = 1;
      end else if (m_state == 1) begin
        d = (int'(z) - m_prev + 4) % 4;
        if (d == 1) begin
          e.step = 1'b1; m_dir = 0; m_pos = (m_pos + 1) % 256;
          m_prev = int'(z); m_cons = 0;
        end else if (d == 3) begin
          e.step = 1'b1; m_dir = 1; m_pos = (m_pos + 255) % 256;
          m_prev = int'(z); m_cons = 0;
        end else if (d == 2) begin
          e.err = 1'b1; m_prev = int'(z); m_cons = m_cons + 1;
          if (m_errcnt < 255) m_errcnt = m_errcnt + 1;
          if (m_cons == ERR_LIMIT) m_state = 2;
        end
      end
    end
    e.dir_out = (m_dir != 0);
    e.locked  = (m_state == 1);
    e.pos     = 8'(m_pos);
`ifdef FSM_UPDOWN_DECODER_ERRCNT_EN
    e.err_cnt = 8'(m_errcnt);
`else
    e.err_cnt = 8'h00;
`endif
    exp_q.push_back(e);
  endtask

  // one transaction: drive on the falling edge, compare 1 time unit after the rise
  task automatic drive(input logic zv, input logic [1:0] z, input logic c);
    exp_t e;
    @(negedge clk);
    bus.z_valid = zv;
    bus.z_in    = z;
    bus.clr     = c;
    model_push(zv, z, c);
    @(posedge clk);
    #1;
    n_txn++;
    $display("txn %0d: zv=%0d z=%0d clr=%0d -> step=%0d err=%0d dir=%0d pos=%02h err_cnt=%0d locked=%0d",
             n_txn, zv, z, c, bus.step, bus.err, bus.dir_out, bus.pos, bus.err_cnt, bus.locked);
    if (exp_q.size() == 0) begin
      check_eq("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq("step",    32'(bus.step),    32'(e.step));
      check_eq("err",     32'(bus.err),     32'(e.err));
      check_eq("dir_out", 32'(bus.dir_out), 32'(e.dir_out));
      check_eq("locked",  32'(bus.locked),  32'(e.locked));
      check_eq("pos",     32'(bus.pos),     32'(e.pos));
      check_eq("err_cnt", 32'(bus.err_cnt), 32'(e.err_cnt));
    end
    bus.z_valid = 1'b0;
    bus.clr     = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_step"},    32'(bus.step),    32'd0);
    check_eq({tag, "_err"},     32'(bus.err),     32'd0);
    check_eq({tag, "_dir"},     32'(bus.dir_out), 32'd0);
    check_eq({tag, "_locked"},  32'(bus.locked),  32'd0);
    check_eq({tag, "_pos"},     32'(bus.pos),     32'd0);
    check_eq({tag, "_err_cnt"}, 32'(bus.err_cnt), 32'd0);
  endtask

  initial begin
    logic [1:0] zs;
    bus.z_in    = 2'd0;
    bus.z_valid = 1'b0;
    bus.clr     = 1'b0;
    reset       = 1'b0;
    model_reset();

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    // up sequence 0,1,2,3,0 -> pos 4, dir up
    drive(1'b1, 2'd0, 1'b0);
    drive(1'b1, 2'd1, 1'b0);
    drive(1'b1, 2'd2, 1'b0);
    drive(1'b1, 2'd3, 1'b0);
    drive(1'b1, 2'd0, 1'b0);
    // idle cycle and a delta-0 sample
    drive(1'b0, 2'd3, 1'b0);
    drive(1'b1, 2'd0, 1'b0);

    // down sequence: lock 0, then 3,2,1,0,3 -> pos 0xFB
    drive(1'b0, 2'd0, 1'b1);
    drive(1'b1, 2'd0, 1'b0);
    drive(1'b1, 2'd3, 1'b0);
    drive(1'b1, 2'd2, 1'b0);
    drive(1'b1, 2'd1, 1'b0);
    drive(1'b1, 2'd0, 1'b0);
    drive(1'b1, 2'd3, 1'b0);

    // positive wrap: 127 up steps to 0x7F, one more to 0x80
    drive(1'b0, 2'd0, 1'b1);
    drive(1'b1, 2'd0, 1'b0);
    for (int i = 1; i <= 128; i++) begin
      zs = 2'(i);
      drive(1'b1, zs, 1'b0);
    end
    // negative wrap from zero
    drive(1'b0, 2'd0, 1'b1);
    drive(1'b1, 2'd2, 1'b0);
    drive(1'b1, 2'd1, 1'b0);

    // illegal jumps into FAULT, then ignored samples, then clr
    drive(1'b0, 2'd0, 1'b1);
    drive(1'b1, 2'd1, 1'b0);
    drive(1'b1, 2'd3, 1'b0);
    drive(1'b1, 2'd1, 1'b0);
    drive(1'b1, 2'd3, 1'b0);
    drive(1'b1, 2'd0, 1'b0);
    drive(1'b1, 2'd1, 1'b0);
    drive(1'b1, 2'd3, 1'b0);
    drive(1'b0, 2'd0, 1'b1);
    // an error run broken by a legal step does not fault
    drive(1'b1, 2'd0, 1'b0);
    drive(1'b1, 2'd2, 1'b0);
    drive(1'b1, 2'd0, 1'b0);
    drive(1'b1, 2'd1, 1'b0);
    drive(1'b1, 2'd3, 1'b0);
    drive(1'b1, 2'd2, 1'b0);

    // clr with z_valid: clr wins, next sample only relocks
    drive(1'b0, 2'd0, 1'b1);
    drive(1'b1, 2'd1, 1'b0);
    drive(1'b1, 2'd2, 1'b1);
    drive(1'b1, 2'd3, 1'b0);
    drive(1'b1, 2'd0, 1'b0);

    // asynchronous reset mid-stream at pos 5
    drive(1'b0, 2'd0, 1'b1);
    drive(1'b1, 2'd0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      zs = 2'(i);
      drive(1'b1, zs, 1'b0);
    end
    @(negedge clk);
    bus.z_valid = 1'b1;
    bus.z_in    = 2'd2;
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(posedge clk);
    #1;
    check_all_zero("reset_hold");
    @(negedge clk);
    reset       = 1'b1;
    bus.z_valid = 1'b0;
    model_reset();
    drive(1'b1, 2'd2, 1'b0);
    drive(1'b1, 2'd3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
